// File: rtl/wordline_write_arbiter_pkg.sv
// Shared types and constants for the word-line write arbiter.
// The array is fixed at 32 entries, so addresses are always 5 bits.
package wordline_write_arbiter_pkg;

  localparam int unsigned AddrW    = 5;
  localparam int unsigned NumWords = 32;
  localparam int unsigned CntW     = 3;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StDrive     = 2'd1,
    StPrecharge = 2'd2
  } state_e;

endpackage

// File: rtl/wordline_write_arbiter_if.sv
// Requester-side and array-side signals of the word-line write arbiter.
interface wordline_write_arbiter_if
  import wordline_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 32
);

  logic [NREQ-1:0]        req;
  logic [NREQ*AddrW-1:0]  req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   hold;
  logic [NREQ-1:0]        ack;
  logic                   wl_enable;
  logic [NumWords-1:0]    WL;
  logic [DATA_W-1:0]      wdata;
  logic                   busy;

  modport master (
    output req, req_addr, req_data, hold,
    input  ack, wl_enable, WL, wdata, busy
  );

  modport slave (
    input  req, req_addr, req_data, hold,
    output ack, wl_enable, WL, wdata, busy
  );

endinterface

// File: rtl/wordline_write_arbiter_decoder5x32.sv
// Combinational 5-to-32 word-line decoder; all lines low when disabled.
module decoder5x32
  import wordline_write_arbiter_pkg::*;
(
  input  logic [AddrW-1:0]    addr_i,
  input  logic                en_i,
  output logic [NumWords-1:0] wl_o
);

  always_comb begin
    wl_o = '0;
    if (en_i) begin
      wl_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/wordline_write_arbiter.sv
// Round-robin arbiter for the single write port of a 32-entry register array:
// grant, one-cycle word-line drive, then a programmable precharge gap.
module wordline_write_arbiter
  import wordline_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned PRECHARGE_CYC = 1
) (
  input logic                     clk,
  input logic                     reset,
  wordline_write_arbiter_if.slave bus
);

  localparam int unsigned PtrW = $clog2(NREQ);

  state_e              state_q, state_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [AddrW-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic [AddrW-1:0]    addr_arr [NREQ];
  logic [DATA_W-1:0]   data_arr [NREQ];
  logic                found;
  logic [PtrW-1:0]     win;
  int unsigned         idx;
  logic                drive;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = bus.req_addr[i*AddrW +: AddrW];
    assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  // First requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && bus.req[idx[PtrW-1:0]]) begin
        found = 1'b1;
        win   = idx[PtrW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = '0;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.hold && found) begin
          state_d    = StDrive;
          addr_d     = addr_arr[win];
          wdata_d    = data_arr[win];
          ack_d[win] = 1'b1;
          rr_ptr_d   = (win == PtrW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      end
      StDrive: begin
        if (PRECHARGE_CYC > 0) begin
          state_d = StPrecharge;
          cnt_d   = CntW'(PRECHARGE_CYC);
        end else begin
          state_d = StIdle;
        end
      end
      StPrecharge: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
    end
  end

  assign drive = (state_q == StDrive);

  decoder5x32 u_decoder (
    .addr_i (addr_q),
    .en_i   (drive),
    .wl_o   (bus.WL)
  );

  assign bus.ack       = ack_q;
  assign bus.wl_enable = drive;
  assign bus.wdata     = wdata_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: doc/wordline_write_arbiter.md
Name: wordline_write_arbiter

Overview:
- Shares the single write port of a 32-entry register array among NREQ requesters using round-robin arbitration.
- Latches the winning request's address and data.
- Drives a one-hot 32-bit word-line select through the 5-to-32 decoder for exactly one cycle, then holds a programmable precharge gap before the next grant.
- Sits between the requesting units and the register-array write port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 32, write data width.
- PRECHARGE_CYC, 1, idle word-line cycles after each write (0..7). 0 allows back-to-back arbitration.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester write request. Held high until ack.
- req_addr  input  NREQ*5  packed addresses; requester i uses bits [5*i+4:5*i].
- req_data  input  NREQ*DATA_W  packed write data; requester i uses slice i.
- hold  input  1  blocks new grants while high. Does not abort a write in flight.
- ack  output  NREQ  one-hot, one-cycle pulse to the granted requester.
- wl_enable  output  1  high during the DRIVE cycle.
- WL  output  32  one-hot word-line select. All zero unless wl_enable is high.
- wdata  output  DATA_W  latched write data. Valid when wl_enable is high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - The design has one clock; reset is synchronous and active-high.
  - When reset is sampled high: state=IDLE, rr_ptr=0, ack=0, wl_enable=0, WL=0, wdata=0, busy=0.
  - Reset mid-DRIVE or mid-PRECHARGE aborts the write. The next cycle shows all outputs zero and no ack is reissued.
- States: IDLE, DRIVE, PRECHARGE.
- IDLE:
  - If hold=0 and req!=0, pick a winner by round-robin: the first set bit at or above rr_ptr, wrapping modulo NREQ.
  - Register the winner's address into addr_q and its data into wdata. Go to DRIVE.
  - Set ack[winner]=1 for the first DRIVE cycle only.
  - Set rr_ptr = (winner+1) mod NREQ.
  - If hold=1 or req=0, stay in IDLE with no ack.
- DRIVE:
  - Lasts exactly 1 cycle.
  - wl_enable=1 and WL = decode(addr_q) via the decoder, with the decoder's enable tied to the registered DRIVE flag.
  - Next state: PRECHARGE if PRECHARGE_CYC>0, else IDLE.
- PRECHARGE:
  - A down-counter is loaded with PRECHARGE_CYC on DRIVE exit.
  - WL=0 and wl_enable=0 throughout.
  - Return to IDLE when the counter reaches 1 (exactly PRECHARGE_CYC cycles).
- Latency and throughput:
  - req sampled in IDLE at cycle t gives ack and WL at cycle t+1.
  - Throughput is one write per (2+PRECHARGE_CYC) cycles. With PRECHARGE_CYC=0 it is one write per 2 cycles, because IDLE always takes one cycle.
- Requester rules:
  - addr and data must be stable while req is high.
  - A requester may drop req the cycle after ack.
  - A req that deasserts before ack is simply never granted.
- Simultaneous events:
  - A request arriving in DRIVE or PRECHARGE waits for IDLE.
  - hold rising during DRIVE has no effect on that write.
  - The requester just granted has lowest priority at the next arbitration.
- Widths:
  - Address width is fixed at 5 to match the 32-entry array.
  - rr_ptr is $clog2(NREQ) bits and wraps with explicit compare against NREQ-1.
- Invariants:
  - ack is at most one-hot.
  - WL is at most one-hot and equals 0 whenever wl_enable=0.

Decomposition:
- Header wl_arbiter_defs.vh, with include guards, holds:
  - the state encodings (IDLE=2'd0, DRIVE=2'd1, PRECHARGE=2'd2);
  - the address width constant (5).
- Sub-module: the existing decoder5x32 is instantiated as the combinational word-line decode.
- The round-robin winner search stays inline; no further sub-modules.

Test Plan:
- Single request: reset, then req=4'b0001, addr0=5'd17, data0=32'hDEADBEEF → next cycle ack=4'b0001, wl_enable=1, WL=32'h0002_0000, wdata=32'hDEADBEEF. Then 1 cycle of WL=0 and busy=1, then busy=0.
- Round-robin fairness: req=4'b1111 held, addresses 0..3 → grant order 0,1,2,3,0 with one write every 3 cycles (PRECHARGE_CYC=1).
- Pointer wrap: rr_ptr=3 after a grant to 2, req=4'b0011 → grant requester 0, then 1.
- Hold: hold=1 with req=4'b0100 for 5 cycles → no ack and WL=0. Drop hold → ack=4'b0100 on the next cycle. Raise hold during DRIVE → that write still completes.
- Reset mid-operation: assert reset during DRIVE → next cycle WL=0, ack=0, busy=0. After release with req still 4'b0010 → requester 1 is granted fresh with rr_ptr starting from 0.
- PRECHARGE_CYC=0 build: req=4'b0011 held → writes 2 cycles apart, grants alternating 0,1,0,1.
